// File: rtl/brush_painter.sv
// brush_painter
//   Writer side of the pixel store's write port. Takes paint and clear
//   commands from the command decoder and expands each one into a stream
//   of single-pixel writes on the CANVAS x CANVAS canvas. Paint commands
//   sweep a (2r+1)x(2r+1) square around the centre, row-major, and silently
//   skip any pixel that lands off the canvas. Clear commands sweep the whole
//   canvas with ERASE_COLOR. Each write is held on wx/wy/newColor/brush
//   until the store accepts it with wrReady.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cmdValid   command present on the cmd* inputs
//   cmdReady   block can accept a command this cycle (state == IDLE)
//   cmdClear   1 = clear whole canvas, 0 = paint
//   cmdX/cmdY  brush centre; bit 7 set means off-canvas
//   cmdColor   paint colour
//   cmdRadius  brush radius r, 0..3
//   wrReady    store accepts the presented write this cycle
//   wx/wy      write coordinate, bit 7 always 0
//   newColor   write colour
//   brush      write valid
//   busy       high while painting or clearing
module brush_painter #(
  parameter int         CANVAS      = 128,
  parameter int         MAX_RADIUS  = 3,
  parameter logic [2:0] ERASE_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdClear,
  input  logic [7:0] cmdX,
  input  logic [7:0] cmdY,
  input  logic [2:0] cmdColor,
  input  logic [1:0] cmdRadius,
  input  logic       wrReady,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] newColor,
  output logic       brush,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PAINT,
    CLEAR
  } state_t;

  localparam logic [7:0] CANVAS_LIM = 8'(CANVAS);
  localparam logic [6:0] LAST_COORD = 7'(CANVAS - 1);
  localparam logic [1:0] MAX_R      = 2'(MAX_RADIUS);

  state_t state, state_next;

  // Command fields latched at acceptance
  logic [7:0]        cx, cx_next;
  logic [7:0]        cy, cy_next;
  logic [2:0]        color_lat, color_lat_next;
  logic signed [3:0] rad, rad_next;

  // Current brush offset within the square
  logic signed [3:0] dx, dx_next;
  logic signed [3:0] dy, dy_next;

  // Registered write port; in CLEAR x_q/y_q double as the sweep counters
  logic [6:0] x_q, x_next;
  logic [6:0] y_q, y_next;
  logic [2:0] color_q, color_next;
  logic       brush_q, brush_next;

  // Candidate pixel for the offset about to be presented
  logic       present;
  logic [8:0] px, py;
  logic       in_range;

  assign cmdReady = (state == IDLE);
  assign busy     = (state == PAINT) || (state == CLEAR);
  assign wx       = {1'b0, x_q};
  assign wy       = {1'b0, y_q};
  assign newColor = color_q;
  assign brush    = brush_q;

  // Next-state and next-output logic. 'present' marks cycles where a new
  // paint offset is loaded onto the write port; the pixel is then either
  // driven with brush=1 or skipped with brush=0 depending on clipping.
  always_comb begin
    state_next     = state;
    cx_next        = cx;
    cy_next        = cy;
    color_lat_next = color_lat;
    rad_next       = rad;
    dx_next        = dx;
    dy_next        = dy;
    x_next         = x_q;
    y_next         = y_q;
    color_next     = color_q;
    brush_next     = brush_q;
    present        = 1'b0;

    case (state)
      IDLE: begin
        brush_next = 1'b0;
        if (cmdValid) begin
          if (cmdClear) begin
            state_next = CLEAR;
            x_next     = '0;
            y_next     = '0;
            color_next = ERASE_COLOR;
            brush_next = 1'b1;
          end else begin
            state_next     = PAINT;
            cx_next        = cmdX;
            cy_next        = cmdY;
            color_lat_next = cmdColor;
            rad_next       = {2'b00, (cmdRadius > MAX_R) ? MAX_R : cmdRadius};
            dx_next        = -rad_next;
            dy_next        = -rad_next;
            present        = 1'b1;
          end
        end
      end

      PAINT: begin
        // A skipped pixel (brush=0) advances unconditionally after one cycle
        if (!brush_q || wrReady) begin
          if ((dx == rad) && (dy == rad)) begin
            state_next = IDLE;
            brush_next = 1'b0;
          end else begin
            if (dx == rad) begin
              dx_next = -rad;
              dy_next = dy + 4'sd1;
            end else begin
              dx_next = dx + 4'sd1;
            end
            present = 1'b1;
          end
        end
      end

      CLEAR: begin
        if (wrReady) begin
          if ((x_q == LAST_COORD) && (y_q == LAST_COORD)) begin
            state_next = IDLE;
            brush_next = 1'b0;
          end else if (x_q == LAST_COORD) begin
            x_next = '0;
            y_next = y_q + 7'd1;
          end else begin
            x_next = x_q + 7'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        brush_next = 1'b0;
      end
    endcase

    // 9-bit sum: anything negative or >= CANVAS has bit 8 set or fails the
    // limit compare, including centres up to 255 plus an offset of +3.
    px       = {1'b0, cx_next} + {{5{dx_next[3]}}, dx_next};
    py       = {1'b0, cy_next} + {{5{dy_next[3]}}, dy_next};
    in_range = !px[8] && (px[7:0] < CANVAS_LIM) &&
               !py[8] && (py[7:0] < CANVAS_LIM);

    if (present) begin
      if (in_range) begin
        x_next     = px[6:0];
        y_next     = py[6:0];
        color_next = color_lat_next;
        brush_next = 1'b1;
      end else begin
        brush_next = 1'b0;
      end
    end
  end

  // State and write-port registers; reset aborts any stroke immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      color_lat <= '0;
      rad       <= '0;
      dx        <= '0;
      dy        <= '0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
      brush_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cx        <= cx_next;
      cy        <= cy_next;
      color_lat <= color_lat_next;
      rad       <= rad_next;
      dx        <= dx_next;
      dy        <= dy_next;
      x_q       <= x_next;
      y_q       <= y_next;
      color_q   <= color_next;
      brush_q   <= brush_next;
    end
  end

endmodule

// File: tb/tb_brush_painter.sv
// tb_brush_painter
//   Directed bench for brush_painter. A negedge monitor records every
//   accepted write (brush && wrReady), counts busy and skipped cycles, and
//   flags any presented write that changes before the store accepts it.
module tb_brush_painter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmdValid = 1'b0;
  logic       cmdClear = 1'b0;
  logic [7:0] cmdX = '0;
  logic [7:0] cmdY = '0;
  logic [2:0] cmdColor = '0;
  logic [1:0] cmdRadius = '0;
  logic       wrReady = 1'b1;
  logic       cmdReady;
  logic [7:0] wx;
  logic [7:0] wy;
  logic [2:0] newColor;
  logic       brush;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [18:0] writes[$];
  int          busyCount = 0;
  int          skipCount = 0;
  int          holdErrs = 0;
  logic        heldValid = 1'b0;
  logic [18:0] heldVal = '0;
  int          rdyMode = 0;

  brush_painter dut (
    .clk      (clk),
    .reset    (reset),
    .cmdValid (cmdValid),
    .cmdReady (cmdReady),
    .cmdClear (cmdClear),
    .cmdX     (cmdX),
    .cmdY     (cmdY),
    .cmdColor (cmdColor),
    .cmdRadius(cmdRadius),
    .wrReady  (wrReady),
    .wx       (wx),
    .wy       (wy),
    .newColor (newColor),
    .brush    (brush),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] pk(input int x, input int y, input int c);
    return {8'(x), 8'(y), 3'(c)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Store model: wrReady always high, or 1 cycle high / 2 cycles low
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rdyMode == 1) begin
        wrReady = (phase == 0);
        phase   = (phase == 2) ? 0 : phase + 1;
      end else begin
        wrReady = 1'b1;
        phase   = 0;
      end
    end
  end

  // Write monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        heldValid = 1'b0;
      end else begin
        if (heldValid && (!brush || ({wx, wy, newColor} != heldVal))) holdErrs++;
        if (brush && wrReady) writes.push_back({wx, wy, newColor});
        if (busy) busyCount++;
        if (busy && !brush) skipCount++;
        heldValid = brush && !wrReady;
        heldVal   = {wx, wy, newColor};
      end
    end
  end

  // Present a command until accepted, then scramble the fields so that
  // anything not latched at acceptance would show up as a wrong write.
  task automatic applyStimulus(input logic clr, input logic [7:0] x, input logic [7:0] y,
                               input logic [2:0] col, input logic [1:0] r);
    int waited = 0;
    @(posedge clk);
    #2;
    cmdValid  = 1'b1;
    cmdClear  = clr;
    cmdX      = x;
    cmdY      = y;
    cmdColor  = col;
    cmdRadius = r;
    forever begin
      @(negedge clk);
      if (cmdReady) break;
      waited++;
      if (waited > 100) begin
        checkOutput("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #2;
    cmdValid  = 1'b0;
    cmdClear  = ~clr;
    cmdX      = 8'hA5;
    cmdY      = 8'h5A;
    cmdColor  = ~col;
    cmdRadius = ~r;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (busy && (n < budget));
    if (busy) checkOutput({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    int wBase, bBase, sBase, hBase, n, bad;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_brush", brush, 0);
    checkOutput("rst_wx", wx, 0);
    checkOutput("rst_wy", wy, 0);
    checkOutput("rst_color", newColor, 0);
    checkOutput("rst_cmdReady", cmdReady, 1);
    checkOutput("rst_busy", busy, 0);
    #1 reset = 1'b0;

    // Test 1: r=0 single pixel, latency check
    @(posedge clk);
    #2;
    wBase     = writes.size();
    cmdValid  = 1'b1;
    cmdClear  = 1'b0;
    cmdX      = 8'd10;
    cmdY      = 8'd20;
    cmdColor  = 3'b010;
    cmdRadius = 2'd0;
    @(posedge clk);
    #2;
    cmdValid = 1'b0;
    cmdX     = 8'd99;
    cmdColor = 3'b111;
    @(negedge clk);
    checkOutput("t1_brush_n1", brush, 1);
    checkOutput("t1_wx", wx, 10);
    checkOutput("t1_wy", wy, 20);
    checkOutput("t1_color", newColor, 3'b010);
    checkOutput("t1_ready_n1", cmdReady, 0);
    @(negedge clk);
    checkOutput("t1_ready_n2", cmdReady, 1);
    checkOutput("t1_brush_n2", brush, 0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t1_count", writes.size() - wBase, 1);
    checkOutput("t1_write", writes[wBase], pk(10, 20, 2));

    // Test 2: corner clip, r=1 at (0,0)
    wBase = writes.size();
    bBase = busyCount;
    sBase = skipCount;
    applyStimulus(1'b0, 8'd0, 8'd0, 3'b100, 2'd1);
    waitIdle("t2", 50);
    checkOutput("t2_count", writes.size() - wBase, 4);
    checkOutput("t2_w0", writes[wBase + 0], pk(0, 0, 4));
    checkOutput("t2_w1", writes[wBase + 1], pk(1, 0, 4));
    checkOutput("t2_w2", writes[wBase + 2], pk(0, 1, 4));
    checkOutput("t2_w3", writes[wBase + 3], pk(1, 1, 4));
    checkOutput("t2_busy", busyCount - bBase, 9);
    checkOutput("t2_skips", skipCount - sBase, 5);

    // Test 3: r=3 at (64,64) with a throttled store
    rdyMode = 1;
    wBase = writes.size();
    hBase = holdErrs;
    applyStimulus(1'b0, 8'd64, 8'd64, 3'b011, 2'd3);
    waitIdle("t3", 400);
    rdyMode = 0;
    checkOutput("t3_count", writes.size() - wBase, 49);
    checkOutput("t3_first", writes[wBase], pk(61, 61, 3));
    checkOutput("t3_last", writes[wBase + 48], pk(67, 67, 3));
    if (writes.size() >= wBase + 49) begin
      for (int k = 0; k < 49; k++)
        checkOutput($sformatf("t3_wr%0d", k), writes[wBase + k],
                    pk(61 + k % 7, 61 + k / 7, 3));
    end
    checkOutput("t3_hold", holdErrs - hBase, 0);

    // Test 4: full clear, with cmdValid pulses while busy
    wBase = writes.size();
    bBase = busyCount;
    applyStimulus(1'b1, 8'd33, 8'd44, 3'b111, 2'd2);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      cmdValid = (i % 2 == 0);
      cmdClear = 1'b0;
      cmdX     = 8'd5;
      cmdY     = 8'd5;
      @(negedge clk);
      if (cmdReady !== 1'b0) bad++;
    end
    cmdValid = 1'b0;
    checkOutput("t4_ready_low", bad, 0);
    waitIdle("t4", 17000);
    checkOutput("t4_count", writes.size() - wBase, 16384);
    checkOutput("t4_busy", busyCount - bBase, 16384);
    checkOutput("t4_first", writes[wBase], pk(0, 0, 0));
    checkOutput("t4_last", writes[wBase + 16383], pk(127, 127, 0));
    bad = 0;
    for (int i = 0; i < 16384; i++)
      if (writes[wBase + i] != pk(i % 128, i / 128, 0)) bad++;
    checkOutput("t4_order", bad, 0);
    repeat (3) @(negedge clk);
    checkOutput("t4_no_queue", busy, 0);

    // Test 5: reset while the 5th pixel is on the port
    wBase = writes.size();
    applyStimulus(1'b0, 8'd64, 8'd64, 3'b101, 2'd1);
    n = 0;
    while ((writes.size() - wBase < 5) && (n < 50)) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("t5_reached5", writes.size() - wBase, 5);
    checkOutput("t5_fifth", writes[wBase + 4], pk(64, 64, 5));
    reset = 1'b1;
    #1;
    checkOutput("t5_brush", brush, 0);
    checkOutput("t5_ready", cmdReady, 1);
    checkOutput("t5_busy", busy, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("t5_nomore", writes.size() - wBase, 5);
    checkOutput("t5_idle", busy, 0);

    // Test 6: fully off-canvas centre
    wBase = writes.size();
    bBase = busyCount;
    applyStimulus(1'b0, 8'd130, 8'd5, 3'b001, 2'd1);
    waitIdle("t6", 50);
    checkOutput("t6_count", writes.size() - wBase, 0);
    checkOutput("t6_busy", busyCount - bBase, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
